score_bcd_converter: RTL and testbench
======================================

SCORE_BCD_CONVERTER -- requirements
Module: score_bcd_converter

Interface
REQ-001 Parameters SHALL be as follows, one per line:
- IN_WIDTH, 16, binary score width; legal range 4..16.
REQ-002 Ports SHALL be as follows, one per line:
- clk  input  1  system clock; all logic is on the rising edge.
- reset  input  1  synchronous, active-high reset.
- score  input  IN_WIDTH  unsigned binary score from the game FSM.
- bcd  output  16  four packed BCD digits, [15:12] thousands down to [3:0] units.
- valid  output  1  high once the first conversion after reset has completed.
- busy  output  1  high while a conversion is in progress.
- updated  output  1  one-cycle pulse in the cycle bcd/overflow change.
- overflow  output  1  last converted score was greater than 9999.

Function
REQ-003 FSM SHALL have exactly three states: IDLE, SHIFT, DONE.
REQ-004 In IDLE, the block SHALL start a conversion if score != last_value or first_pending=1.
- The load cycle captures score into a 20-bit digit field (5 BCD digits) plus an IN_WIDTH binary field.
- The load cycle clears the shift counter and moves to SHIFT.
REQ-005 Each SHIFT cycle SHALL:
- Add 3 to every 4-bit digit whose value is >=5.
- Then shift the combined register left by 1 bit.
- Increment the counter.
REQ-006 After exactly IN_WIDTH shift cycles, the FSM SHALL move to DONE.
REQ-007 In DONE, the block SHALL:
- Register bcd and overflow.
- Set valid=1 and pulse updated=1.
- Store last_value = captured score and clear first_pending.
- Return to IDLE.
REQ-008 Latency SHALL be IN_WIDTH+2 cycles from the load cycle to the updated pulse (18 cycles at IN_WIDTH=16).
REQ-009 busy SHALL be 1 in SHIFT and DONE, and 0 in IDLE.
REQ-010 score changes during SHIFT/DONE SHALL be ignored. The next IDLE cycle re-evaluates score, so only the latest value is converted and no intermediate value is queued.
REQ-011 bcd and overflow SHALL hold their value between DONE cycles and never show partial results.
REQ-012 overflow SHALL be 1 iff the ten-thousands digit is nonzero. For example, 9999 gives overflow=0 and 10000 gives overflow=1.
REQ-013 updated SHALL pulse even when the new bcd equals the previous bcd.
REQ-014 Scores with unchanged value SHALL NOT retrigger a conversion after the first one.

Reset
REQ-015 reset SHALL take priority over all other activity. On the next clock edge:
- state=IDLE and counter=0.
- bcd=16'h0000, valid=0, busy=0, updated=0, overflow=0.
- last_value=0 and first_pending=1.
REQ-016 A reset asserted mid-conversion SHALL abort it with no updated pulse. Conversion restarts in the first IDLE cycle after reset deasserts.

Configuration
REQ-017 When macro BCD_CLAMP_EN is defined, an overflowing score SHALL produce bcd=16'h9999.
REQ-018 When BCD_CLAMP_EN is undefined, an overflowing score SHALL produce bcd = lower four digits (score mod 10000).
REQ-019 overflow SHALL behave identically with or without BCD_CLAMP_EN, and latency is unchanged.

Verification
REQ-020 Post-reset start-up: reset 2 cycles, score=0.
- updated pulses 18 cycles after the first IDLE cycle.
- bcd=16'h0000, valid=1, overflow=0.
- No further pulses while score is unchanged.
REQ-021 Normal value: score=1234 -> after 18 cycles bcd=16'h1234, overflow=0, and busy high for exactly 17 cycles.
REQ-022 Boundary values:
- score=9999 -> bcd=16'h9999, overflow=0.
- score=10000 -> overflow=1; bcd=16'h9999 with BCD_CLAMP_EN, 16'h0000 without.
REQ-023 Maximum value: score=65535 -> overflow=1; bcd=16'h9999 with BCD_CLAMP_EN, 16'h5535 without.
REQ-024 Change mid-conversion: score=12, then score=34 on cycle 5 of SHIFT.
- First updated pulse shows bcd=16'h0012.
- A second conversion starts immediately.
- Second pulse shows bcd=16'h0034, with no intermediate value.
REQ-025 Reset mid-conversion: score=777, reset asserted on SHIFT cycle 8.
- Next cycle: bcd=0, valid=0, busy=0, no updated pulse.
- After release, bcd=16'h0777 appears 18 cycles later.

Source files
------------

// File: rtl/score_bcd_converter.sv
// score_bcd_converter: serial double-dabble binary-to-BCD converter for a
// game score display. A conversion takes IN_WIDTH shift cycles bracketed by
// a load cycle and a DONE cycle. Outputs update only in DONE, so the display
// never sees a partially converted value.
// Optional build macro: BCD_CLAMP_EN -- scores above 9999 show as 9999
// instead of wrapping to score mod 10000.
module score_bcd_converter #(
  parameter int IN_WIDTH = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [IN_WIDTH-1:0] score,
  output logic [15:0]         bcd,
  output logic                valid,
  output logic                busy,
  output logic                updated,
  output logic                overflow
);

  // 5 BCD digits on top of the binary field; the binary bits are shifted
  // into the digit field one per SHIFT cycle.
  localparam int SR_W  = 20 + IN_WIDTH;
  localparam int CNT_W = $clog2(IN_WIDTH + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t              state_q, state_d;
  logic [SR_W-1:0]     sr_q, sr_d, sr_adj;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [IN_WIDTH-1:0] cap_q, cap_d;
  logic [IN_WIDTH-1:0] last_q, last_d;
  logic                first_pending_q, first_pending_d;
  logic [15:0]         bcd_q, bcd_d;
  logic                valid_q, valid_d;
  logic                busy_q, busy_d;
  logic                updated_q, updated_d;
  logic                overflow_q, overflow_d;
  logic [19:0]         digits;

  assign digits = sr_q[SR_W-1 -: 20];

  // Double-dabble correction: bump every digit >= 5 by 3 before the shift.
  always_comb begin
    sr_adj = sr_q;
    for (int i = 0; i < 5; i++) begin
      if (sr_q[IN_WIDTH + 4*i +: 4] >= 4'd5)
        sr_adj[IN_WIDTH + 4*i +: 4] = sr_q[IN_WIDTH + 4*i +: 4] + 4'd3;
    end
  end

  // Next-state and next-output logic for the IDLE/SHIFT/DONE sequence.
  always_comb begin
    state_d         = state_q;
    sr_d            = sr_q;
    cnt_d           = cnt_q;
    cap_d           = cap_q;
    last_d          = last_q;
    first_pending_d = first_pending_q;
    bcd_d           = bcd_q;
    valid_d         = valid_q;
    busy_d          = busy_q;
    updated_d       = 1'b0;
    overflow_d      = overflow_q;
    case (state_q)
      IDLE: begin
        // Only the score present in this cycle is converted; changes made
        // while busy are picked up here on the way back.
        if (score != last_q || first_pending_q) begin
          sr_d    = {20'd0, score};
          cap_d   = score;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        sr_d  = {sr_adj[SR_W-2:0], 1'b0};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(IN_WIDTH - 1))
          state_d = DONE;
      end
      DONE: begin
        overflow_d = (digits[19:16] != 4'd0);
`ifdef BCD_CLAMP_EN
        bcd_d = (digits[19:16] != 4'd0) ? 16'h9999 : digits[15:0];
`else
        bcd_d = digits[15:0];
`endif
        valid_d         = 1'b1;
        updated_d       = 1'b1;
        last_d          = cap_q;
        first_pending_d = 1'b0;
        busy_d          = 1'b0;
        state_d         = IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // State and registered outputs; reset aborts any conversion in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= IDLE;
      sr_q            <= '0;
      cnt_q           <= '0;
      cap_q           <= '0;
      last_q          <= '0;
      first_pending_q <= 1'b1;
      bcd_q           <= 16'h0000;
      valid_q         <= 1'b0;
      busy_q          <= 1'b0;
      updated_q       <= 1'b0;
      overflow_q      <= 1'b0;
    end else begin
      state_q         <= state_d;
      sr_q            <= sr_d;
      cnt_q           <= cnt_d;
      cap_q           <= cap_d;
      last_q          <= last_d;
      first_pending_q <= first_pending_d;
      bcd_q           <= bcd_d;
      valid_q         <= valid_d;
      busy_q          <= busy_d;
      updated_q       <= updated_d;
      overflow_q      <= overflow_d;
    end
  end

  assign bcd      = bcd_q;
  assign valid    = valid_q;
  assign busy     = busy_q;
  assign updated  = updated_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_score_bcd_converter.sv
// Directed bench for score_bcd_converter (IN_WIDTH=16). Expected BCD values
// are hand-computed; define BCD_CLAMP_EN here too when building the clamp
// variant of the design.
module tb_score_bcd_converter;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] score;
  logic [15:0] bcd;
  logic        valid, busy, updated, overflow;

  int checks   = 0;
  int failures = 0;

  score_bcd_converter #(.IN_WIDTH(16)) dut (
    .clk(clk), .reset(reset), .score(score), .bcd(bcd),
    .valid(valid), .busy(busy), .updated(updated), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Counts rising edges until updated is seen (sampled 1 time unit after the
  // edge); n includes the load edge. Also counts edges with busy high.
  task automatic wait_upd(input string tag, output int n, output int nbusy);
    n = 0;
    nbusy = 0;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk); #1;
      n++;
      if (busy) nbusy++;
      if (updated) return;
    end
    chk({tag, "_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic convert(input string tag, input logic [15:0] s,
                         input logic [15:0] exp_bcd, input logic exp_ovf);
    int n, nb;
    @(negedge clk);
    score = s;
    wait_upd(tag, n, nb);
    chk({tag, "_lat"}, n, 18);
    chk({tag, "_bcd"}, bcd, exp_bcd);
    chk({tag, "_ovf"}, overflow, exp_ovf);
  endtask

  logic [15:0] exp10000, exp65535;

  initial begin
    int n, nb, pulses;
`ifdef BCD_CLAMP_EN
    exp10000 = 16'h9999;
    exp65535 = 16'h9999;
`else
    exp10000 = 16'h0000;
    exp65535 = 16'h5535;
`endif
    reset = 1'b1;
    score = 16'd0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_bcd", bcd, 16'h0000);
    chk("rst_valid", valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_upd", updated, 1'b0);
    chk("rst_ovf", overflow, 1'b0);

    // Start-up conversion of score 0
    @(negedge clk);
    reset = 1'b0;
    wait_upd("boot", n, nb);
    chk("boot_lat", n, 18);
    chk("boot_bcd", bcd, 16'h0000);
    chk("boot_valid", valid, 1'b1);
    chk("boot_ovf", overflow, 1'b0);
    pulses = 0;
    repeat (30) begin
      @(posedge clk); #1;
      if (updated) pulses++;
    end
    chk("boot_nopulse", pulses, 0);

    // Normal value with busy width
    @(negedge clk);
    score = 16'd1234;
    wait_upd("v1234", n, nb);
    chk("v1234_lat", n, 18);
    chk("v1234_busy", nb, 17);
    chk("v1234_bcd", bcd, 16'h1234);
    chk("v1234_ovf", overflow, 1'b0);
    @(posedge clk); #1;
    chk("v1234_pulse1", updated, 1'b0);

    convert("v9999", 16'd9999, 16'h9999, 1'b0);
    // 19999 also shows 9999 either way: pulse must still occur
    convert("v19999", 16'd19999, 16'h9999, 1'b1);
    convert("v10000", 16'd10000, exp10000, 1'b1);
    convert("v65535", 16'd65535, exp65535, 1'b1);
    convert("v0", 16'd0, 16'h0000, 1'b0);

    // Score change during SHIFT cycle 5
    @(negedge clk);
    score = 16'd12;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
    end
    score = 16'd34;
    n = 5;
    for (int i = 0; i < 60 && !updated; i++) begin
      @(posedge clk); #1;
      n++;
      if (!updated) chk("mid_hold", bcd, 16'h0000);
    end
    chk("mid1_lat", n, 18);
    chk("mid1_bcd", bcd, 16'h0012);
    wait_upd("mid2", n, nb);
    chk("mid2_lat", n, 18);
    chk("mid2_bcd", bcd, 16'h0034);

    // Reset during SHIFT cycle 8
    @(negedge clk);
    score = 16'd777;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
    end
    reset = 1'b1;
    @(posedge clk); #1;
    chk("mrst_bcd", bcd, 16'h0000);
    chk("mrst_valid", valid, 1'b0);
    chk("mrst_busy", busy, 1'b0);
    chk("mrst_upd", updated, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    wait_upd("mrst", n, nb);
    chk("mrst_lat", n, 18);
    chk("mrst_res", bcd, 16'h0777);
    chk("mrst_valid2", valid, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
